// File: rtl/haz_issue_scheduler.sv
// Scoreboard issue controller: per-register result countdowns gate RAW/WAW hazards,
// select bypass for operands whose producer lands on the bypass in the issue cycle.
module haz_issue_scheduler #(
   parameter int NREG   = 8,
   parameter int LAT_W  = 2,
   parameter int SCNT_W = 8,
   localparam int RW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RW-1:0]     in_rs1,
   input  logic [RW-1:0]     in_rs2,
   input  logic [RW-1:0]     in_rd,
   input  logic              in_wen,
   input  logic [LAT_W-1:0]  in_lat,
   output logic              issue_valid,
   output logic [RW-1:0]     issue_rd,
   output logic              issue_wen,
   output logic              fwd1,
   output logic              fwd2,
   output logic [1:0]        state,
   output logic [SCNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_STALL = 2'b10} st_t;

   st_t              st;
   logic [LAT_W-1:0] cnt     [NREG];
   logic [LAT_W-1:0] cnt_nxt [NREG];
   logic [LAT_W-1:0] lat_eff;
   logic             raw1, raw2, waw, accept, stall, load, any_nxt;
   logic             fwd1_d, fwd2_d, rd_nz;

   assign lat_eff = (in_lat == '0) ? LAT_W'(1) : in_lat;
   assign rd_nz   = (in_rd != '0);

   // cnt>=2 means the producer result is not yet on the bypass for an issue next cycle
   assign raw1 = (in_rs1 != '0) && (cnt[in_rs1] >= LAT_W'(2));
   assign raw2 = (in_rs2 != '0) && (cnt[in_rs2] >= LAT_W'(2));
   assign waw  = in_wen && rd_nz && (cnt[in_rd] != '0) && (cnt[in_rd] >= lat_eff);

   assign in_ready = ena && !(raw1 || raw2 || waw);
   assign accept   = in_valid && in_ready;
   assign stall    = in_valid && ena && !in_ready;
   assign load     = accept && in_wen && rd_nz;

   assign fwd1_d = (in_rs1 != '0) && (cnt[in_rs1] == LAT_W'(1));
   assign fwd2_d = (in_rs2 != '0) && (cnt[in_rs2] == LAT_W'(1));

   assign cnt_nxt[0] = '0;
   genvar g;
   for (g = 1; g < NREG; g++) begin : g_sb
      assign cnt_nxt[g] = (load && in_rd == RW'(g)) ? lat_eff :
                          (cnt[g] != '0)             ? cnt[g] - LAT_W'(1) : '0;
   end

   always_comb begin
      any_nxt = 1'b0;
      for (int r = 1; r < NREG; r++)
         if (cnt_nxt[r] != '0) any_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
         issue_valid <= 1'b0;
         issue_rd    <= '0;
         issue_wen   <= 1'b0;
         fwd1        <= 1'b0;
         fwd2        <= 1'b0;
         stall_cnt   <= '0;
         st          <= S_IDLE;
      end else begin
         for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
         issue_valid <= accept;
         issue_rd    <= accept ? in_rd : '0;
         issue_wen   <= load;
         fwd1        <= accept && fwd1_d;
         fwd2        <= accept && fwd2_d;
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + SCNT_W'(1);
         if (stall)                    st <= S_STALL;
         else if (any_nxt || accept)   st <= S_RUN;
         else                          st <= S_IDLE;
      end
   end

   assign state = st;

endmodule

// File: tb/tb_haz_issue_scheduler.sv
// Bench for haz_issue_scheduler: directed vector table, saturation/reset sequence,
// and random traffic against a timestamp-based scoreboard model.
module tb_haz_issue_scheduler;

   logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, in_valid = 1'b0, in_ready;
   logic [2:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, issue_rd;
   logic       in_wen = 1'b0, issue_valid, issue_wen, fwd1, fwd2;
   logic [1:0] in_lat = '0, state;
   logic [7:0] stall_cnt;

   int n_chk = 0, n_fail = 0;

   haz_issue_scheduler #(.NREG(8), .LAT_W(2), .SCNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_lat(in_lat),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
      .fwd1(fwd1), .fwd2(fwd2), .state(state), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic v, en; logic [2:0] rs1, rs2, rd; logic wen; logic [1:0] lat;
      logic rdy, iv; logic [2:0] ird; logic iwen, f1, f2; logic [1:0] st; int sc;
   } vec_t;

   function automatic vec_t mkv(input logic v, en, input logic [2:0] rs1, rs2, rd,
                                input logic wen, input logic [1:0] lat, input logic rdy, iv,
                                input logic [2:0] ird, input logic iwen, f1, f2,
                                input logic [1:0] st, input int sc);
      vec_t t;
      t.v = v; t.en = en; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.wen = wen; t.lat = lat;
      t.rdy = rdy; t.iv = iv; t.ird = ird; t.iwen = iwen; t.f1 = f1; t.f2 = f2;
      t.st = st; t.sc = sc;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Called near a negedge: drive, check in_ready, clock, check registered outputs.
   task automatic run_vec(input vec_t t, input string nm);
      in_valid = t.v; ena = t.en; in_rs1 = t.rs1; in_rs2 = t.rs2;
      in_rd = t.rd; in_wen = t.wen; in_lat = t.lat;
      #1;
      chk({nm, ".in_ready"}, 32'(in_ready), 32'(t.rdy));
      @(posedge clk); #1;
      chk({nm, ".issue_valid"}, 32'(issue_valid), 32'(t.iv));
      chk({nm, ".issue_rd"},    32'(issue_rd),    32'(t.ird));
      chk({nm, ".issue_wen"},   32'(issue_wen),   32'(t.iwen));
      chk({nm, ".fwd1"},        32'(fwd1),        32'(t.f1));
      chk({nm, ".fwd2"},        32'(fwd2),        32'(t.f2));
      chk({nm, ".state"},       32'(state),       32'(t.st));
      chk({nm, ".stall_cnt"},   32'(stall_cnt),   32'(t.sc));
      @(negedge clk);
   endtask

   // Model: done_c[r] is the cycle in which a consumer of r may be accepted and
   // pick the result off the bypass; earlier is a RAW, later reads the regfile.
   int cyc, m_sc;
   int done_c [8];

   function automatic void model_reset();
      for (int r = 0; r < 8; r++) done_c[r] = -100;
      cyc = 0; m_sc = 0;
   endfunction

   function automatic void model_eval(inout vec_t t);
      int  le, left;
      bit  r1, r2, w, acc, stl, busy;
      le   = (t.lat == 0) ? 1 : int'(t.lat);
      left = done_c[t.rd] - cyc + 1;
      r1   = (t.rs1 != 0) && (cyc < done_c[t.rs1]);
      r2   = (t.rs2 != 0) && (cyc < done_c[t.rs2]);
      w    = t.wen && (t.rd != 0) && (left >= 1) && (left >= le);
      t.rdy = t.en && !(r1 || r2 || w);
      acc  = t.v && t.rdy;
      stl  = t.v && t.en && !t.rdy;
      t.iv   = acc;
      t.ird  = acc ? t.rd : 3'd0;
      t.iwen = acc && t.wen && (t.rd != 0);
      t.f1   = acc && (t.rs1 != 0) && (cyc == done_c[t.rs1]);
      t.f2   = acc && (t.rs2 != 0) && (cyc == done_c[t.rs2]);
      if (acc && t.wen && t.rd != 0) done_c[t.rd] = cyc + le;
      if (stl && m_sc < 255) m_sc++;
      cyc++;
      busy = acc;
      for (int r = 1; r < 8; r++) if (done_c[r] >= cyc) busy = 1;
      t.st = stl ? 2'd2 : (busy ? 2'd1 : 2'd0);
      t.sc = m_sc;
   endfunction

   task automatic check_cleared(input string nm);
      chk({nm, ".issue_valid"}, 32'(issue_valid), 0);
      chk({nm, ".issue_rd"},    32'(issue_rd),    0);
      chk({nm, ".issue_wen"},   32'(issue_wen),   0);
      chk({nm, ".fwd"},         32'({fwd1, fwd2}), 0);
      chk({nm, ".state"},       32'(state),       0);
      chk({nm, ".stall_cnt"},   32'(stall_cnt),   0);
   endtask

   // Present one instruction under the model until accepted (bounded).
   task automatic issue_until_acc(input vec_t base, input string nm);
      vec_t t;
      bit   ok = 0;
      for (int k = 0; k < 8 && !ok; k++) begin
         t = base;
         model_eval(t);
         run_vec(t, nm);
         ok = t.rdy;
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL %s.accept_timeout: not accepted in 8 cycles", nm);
      end
   endtask

   vec_t tab [26];
   vec_t t, cur, prod, cons;
   bit   pend;

   initial begin
      //            v en rs1 rs2 rd wen lat  rdy iv ird iwen f1 f2 st sc
      tab[0]  = mkv(1, 1, 0, 0, 2, 1, 3,  1, 1, 2, 1, 0, 0, 1, 0);
      tab[1]  = mkv(1, 1, 5, 6, 7, 1, 1,  1, 1, 7, 1, 0, 0, 1, 0);
      tab[2]  = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0);
      tab[3]  = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
      tab[4]  = mkv(1, 1, 0, 0, 3, 1, 3,  1, 1, 3, 1, 0, 0, 1, 0);
      tab[5]  = mkv(1, 1, 3, 0, 5, 1, 1,  0, 0, 0, 0, 0, 0, 2, 1);
      tab[6]  = mkv(1, 1, 3, 0, 5, 1, 1,  0, 0, 0, 0, 0, 0, 2, 2);
      tab[7]  = mkv(1, 1, 3, 0, 5, 1, 1,  1, 1, 5, 1, 1, 0, 1, 2);
      tab[8]  = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 2);
      tab[9]  = mkv(1, 1, 0, 0, 4, 1, 3,  1, 1, 4, 1, 0, 0, 1, 2);
      tab[10] = mkv(1, 1, 0, 0, 4, 1, 1,  0, 0, 0, 0, 0, 0, 2, 3);
      tab[11] = mkv(1, 1, 0, 0, 4, 1, 1,  0, 0, 0, 0, 0, 0, 2, 4);
      tab[12] = mkv(1, 1, 0, 0, 4, 1, 1,  0, 0, 0, 0, 0, 0, 2, 5);
      tab[13] = mkv(1, 1, 0, 0, 4, 1, 1,  1, 1, 4, 1, 0, 0, 1, 5);
      tab[14] = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 5);
      tab[15] = mkv(1, 1, 0, 0, 0, 1, 3,  1, 1, 0, 0, 0, 0, 1, 5);
      tab[16] = mkv(1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1, 5);
      tab[17] = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 5);
      tab[18] = mkv(1, 0, 0, 0, 6, 1, 2,  0, 0, 0, 0, 0, 0, 0, 5);
      tab[19] = mkv(1, 1, 0, 0, 6, 1, 0,  1, 1, 6, 1, 0, 0, 1, 5);
      tab[20] = mkv(1, 1, 6, 6, 1, 0, 0,  1, 1, 1, 0, 1, 1, 1, 5);
      tab[21] = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 5);
      tab[22] = mkv(1, 1, 2, 0, 2, 1, 3,  1, 1, 2, 1, 0, 0, 1, 5);
      tab[23] = mkv(1, 1, 0, 2, 2, 1, 3,  0, 0, 0, 0, 0, 0, 2, 6);
      tab[24] = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 6);
      tab[25] = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 6);

      // Reset state
      repeat (2) @(negedge clk);
      check_cleared("reset");
      ena = 1'b1;
      rst_n = 1'b1;
      #1 chk("reset.in_ready", 32'(in_ready), 1);
      @(negedge clk);

      for (int i = 0; i < 26; i++) run_vec(tab[i], $sformatf("vec%0d", i));

      // Saturation: 150 producer/consumer pairs, two RAW stalls each
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_reset();
      prod = mkv(1, 1, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      cons = mkv(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int p = 0; p < 150; p++) begin
         issue_until_acc(prod, "sat.prod");
         issue_until_acc(cons, "sat.cons");
      end
      chk("sat.stall_cnt", 32'(stall_cnt), 255);
      issue_until_acc(prod, "sat.prod");
      t = cons; model_eval(t); run_vec(t, "sat.stall");
      #2 rst_n = 1'b0;
      #1 check_cleared("sat.async_rst");
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1; model_reset();

      // Random traffic; stalled instructions are held until accepted
      pend = 0;
      for (int i = 0; i < 600; i++) begin
         if (!pend) begin
            cur.v   = ($urandom % 4) != 0;
            cur.rs1 = 3'($urandom % 4);
            cur.rs2 = 3'($urandom % 4);
            cur.rd  = 3'($urandom % 4);
            cur.wen = 1'($urandom % 2);
            cur.lat = 2'($urandom % 4);
         end
         cur.en = ($urandom % 8) != 0;
         t = cur;
         model_eval(t);
         run_vec(t, "rnd");
         pend = t.v && !t.rdy;
         if (i == 300) begin
            // Mid-run reset, release with decode idle
            rst_n = 1'b0;
            #2 check_cleared("midrun_rst");
            in_valid = 1'b0; ena = 1'b1;
            @(negedge clk); rst_n = 1'b1; model_reset(); pend = 0;
            #1 chk("midrun_rst.in_ready", 32'(in_ready), 1);
            @(negedge clk);
            cyc = 1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
